// File: rtl/sprite_pkg.sv
// Shared constants, types and the per-axis bounce rule for the sprite motion block.
package sprite_pkg;

  localparam int SCREEN_WID = 640;
  localparam int SCREEN_HGT = 480;
  localparam int SPR_WID    = 40;
  localparam int SPR_HGT    = 40;
  localparam int MAX_X      = SCREEN_WID - SPR_WID;
  localparam int MAX_Y      = SCREEN_HGT - SPR_HGT;

  // Position arithmetic is done one bit wider than the screen so x+step never wraps.
  localparam int COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } motion_state_e;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  typedef struct packed {
    coord_t pos;
    dir_e   dir;
    logic   flip;
  } axis_step_t;

  // One axis step: advance by step, clamp at either wall and reverse direction there.
  function automatic axis_step_t step_axis(input coord_t pos, input dir_e dir,
                                           input coord_t step, input coord_t max_pos);
    axis_step_t r;
    coord_t     sum;
    sum    = pos + step;
    r.pos  = pos;
    r.dir  = dir;
    r.flip = 1'b0;
    if (dir == DIR_POS) begin
      if (sum >= max_pos) begin
        r.pos  = max_pos;
        r.dir  = DIR_NEG;
        r.flip = 1'b1;
      end else begin
        r.pos = sum;
      end
    end else begin
      if (pos <= step) begin
        r.pos  = '0;
        r.dir  = DIR_POS;
        r.flip = 1'b1;
      end else begin
        r.pos = pos - step;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_frame_tick.sv
// One-cycle frame tick on the first clock the raster sits on the last visible pixel.
// The raster may dwell on a pixel for several clocks; the edge detect keeps it to one tick.
module sprite_frame_tick
  import sprite_pkg::*;
#(
  parameter int X_W   = 10,
  parameter int Y_W   = 9,
  parameter int END_X = SCREEN_WID - 1,
  parameter int END_Y = SCREEN_HGT - 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [X_W-1:0] raster_x,
  input  logic [Y_W-1:0] raster_y,
  output logic           tick
);

  logic end_cond;
  logic end_q;

  assign end_cond = (raster_x == X_W'(END_X)) && (raster_y == Y_W'(END_Y));

  // Remember last cycle's end condition so only its rising edge produces a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) end_q <= 1'b0;
    else        end_q <= end_cond;
  end

  assign tick = end_cond & ~end_q;

endmodule

// File: rtl/sprite_motion.sv
// Bouncing-sprite position generator feeding the 40x40 sprite renderer.
// Position is recomputed once per (divided) frame during blanking: tick -> CALC -> COMMIT,
// so the renderer always sees a stable origin for the whole visible frame.
module sprite_motion
  import sprite_pkg::*;
#(
  parameter int STEP_X    = 2,
  parameter int STEP_Y    = 1,
  parameter int FRAME_DIV = 1,
  parameter int INIT_X    = 300,
  parameter int INIT_Y    = 220
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [9:0] RASTER_X,
  input  logic [8:0] RASTER_Y,
  input  logic       ENABLE,
  input  logic       PAUSE,
  output logic [9:0] SPRITE_ORIGIN_OFFSET_X,
  output logic [8:0] SPRITE_ORIGIN_OFFSET_Y,
  output logic       VISIBLE,
  output logic       BOUNCE
);

  motion_state_e state, state_next;
  logic          tick;
  logic          latch_vis, do_calc, do_commit;
  logic          move_now;
  logic [7:0]    div_cnt;

  coord_t        x_q, y_q, nx_q, ny_q;
  dir_e          dir_x_q, dir_y_q, ndir_x_q, ndir_y_q;
  logic          nflip_q;
  logic          visible_q, bounce_q;
  axis_step_t    step_x, step_y;
  logic          unused_hi;

  sprite_frame_tick #(
    .X_W (10),
    .Y_W (9)
  ) u_frame_tick (
    .clk      (CLK),
    .rst_n    (RESET),
    .raster_x (RASTER_X),
    .raster_y (RASTER_Y),
    .tick     (tick)
  );

  assign move_now = (div_cnt == 8'(FRAME_DIV - 1));
  assign step_x   = step_axis(x_q, dir_x_q, coord_t'(STEP_X), coord_t'(MAX_X));
  assign step_y   = step_axis(y_q, dir_y_q, coord_t'(STEP_Y), coord_t'(MAX_Y));

  // Motion FSM state register.
  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and per-state strobes; a tick outside IDLE is simply ignored.
  // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_next = state;
    latch_vis  = 1'b0;
    do_calc    = 1'b0;
    do_commit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick) begin
          latch_vis = 1'b1;
          if (!PAUSE) state_next = CALC;
        end
      end
      CALC: begin
        do_calc    = 1'b1;
        state_next = COMMIT;
      end
      COMMIT: begin
        do_commit  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // CALC stage: advance the frame divider and fill the next-position holding registers.
  // NOTE: the holding registers are reset as well, so an aborted update leaves nothing stale.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      div_cnt  <= '0;
      nx_q     <= coord_t'(INIT_X);
      ny_q     <= coord_t'(INIT_Y);
      ndir_x_q <= DIR_POS;
      ndir_y_q <= DIR_POS;
      nflip_q  <= 1'b0;
    end else if (do_calc) begin
      if (move_now) begin
        div_cnt  <= '0;
        nx_q     <= step_x.pos;
        ny_q     <= step_y.pos;
        ndir_x_q <= step_x.dir;
        ndir_y_q <= step_y.dir;
        nflip_q  <= step_x.flip | step_y.flip;
      end else begin
        div_cnt  <= div_cnt + 8'd1;
        nx_q     <= x_q;
        ny_q     <= y_q;
        ndir_x_q <= dir_x_q;
        ndir_y_q <= dir_y_q;
        nflip_q  <= 1'b0;
      end
    end
  end

  // COMMIT stage and visibility: publish the new origin, pulse BOUNCE, latch ENABLE at tick.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      x_q       <= coord_t'(INIT_X);
      y_q       <= coord_t'(INIT_Y);
      dir_x_q   <= DIR_POS;
      dir_y_q   <= DIR_POS;
      visible_q <= 1'b0;
      bounce_q  <= 1'b0;
    end else begin
      bounce_q <= do_commit & nflip_q;
      if (latch_vis) visible_q <= ENABLE;
      if (do_commit) begin
        x_q     <= nx_q;
        y_q     <= ny_q;
        dir_x_q <= ndir_x_q;
        dir_y_q <= ndir_y_q;
      end
    end
  end

  // Positions are clamped to MAX_X/MAX_Y, so the spare high bits are always zero.
  assign unused_hi = ^{x_q[10], y_q[10:9]};

  assign SPRITE_ORIGIN_OFFSET_X = x_q[9:0];
  assign SPRITE_ORIGIN_OFFSET_Y = y_q[8:0];
  assign VISIBLE                = visible_q;
  assign BOUNCE                 = bounce_q;

endmodule

// File: tb/tb_sprite_motion.sv
// Self-checking bench: five differently parameterised instances share one raster bus and
// are compared cycle by cycle against a velocity-based reference model.
module tb_sprite_motion;

  localparam int N = 5;
  localparam int P_IX  [N] = '{300, 598, 600, 300, 300};
  localparam int P_IY  [N] = '{220, 220, 440, 220, 220};
  localparam int P_SX  [N] = '{2, 2, 2, 2, 31};
  localparam int P_SY  [N] = '{1, 1, 1, 1, 31};
  localparam int P_DIV [N] = '{1, 1, 1, 3, 1};
  localparam int LIM_X = 640 - 40;
  localparam int LIM_Y = 480 - 40;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [9:0] RASTER_X;
  logic [8:0] RASTER_Y;
  logic       ENABLE;
  logic       PAUSE;

  logic [9:0] ox   [N];
  logic [8:0] oy   [N];
  logic       ovis [N];
  logic       obnc [N];

  int m_x [N], m_y [N], m_dx [N], m_dy [N], m_cnt [N], m_vis [N], m_bnc [N];
  int old_x [N], old_y [N];
  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < N; g++) begin : g_dut
    sprite_motion #(
      .STEP_X    (P_SX[g]),
      .STEP_Y    (P_SY[g]),
      .FRAME_DIV (P_DIV[g]),
      .INIT_X    (P_IX[g]),
      .INIT_Y    (P_IY[g])
    ) u_dut (
      .CLK                    (CLK),
      .RESET                  (RESET),
      .RASTER_X               (RASTER_X),
      .RASTER_Y               (RASTER_Y),
      .ENABLE                 (ENABLE),
      .PAUSE                  (PAUSE),
      .SPRITE_ORIGIN_OFFSET_X (ox[g]),
      .SPRITE_ORIGIN_OFFSET_Y (oy[g]),
      .VISIBLE                (ovis[g]),
      .BOUNCE                 (obnc[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_inst(input int i, input string phase, input int ex, input int ey,
                            input int ev, input int eb);
    check($sformatf("%s_d%0d_x", phase, i),   32'(ox[i]),   ex);
    check($sformatf("%s_d%0d_y", phase, i),   32'(oy[i]),   ey);
    check($sformatf("%s_d%0d_vis", phase, i), 32'(ovis[i]), ev);
    check($sformatf("%s_d%0d_bnc", phase, i), 32'(obnc[i]), eb);
  endtask

  // Reference model: signed velocity per axis, clamped to [0, limit].
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_x[i] = P_IX[i];  m_y[i] = P_IY[i];
      m_dx[i] = 1;       m_dy[i] = 1;
      m_cnt[i] = 0;      m_vis[i] = 0;  m_bnc[i] = 0;
      old_x[i] = m_x[i]; old_y[i] = m_y[i];
    end
  endtask

  task automatic move_axis(inout int p, inout int d, input int s, input int lim, output bit f);
    p = p + d * s;
    f = 1'b0;
    if (p >= lim) begin
      p = lim; d = -1; f = 1'b1;
    end else if (p <= 0) begin
      p = 0;   d = 1;  f = 1'b1;
    end
  endtask

  task automatic model_tick(input bit en, input bit pa);
    bit fx, fy;
    for (int i = 0; i < N; i++) begin
      old_x[i] = m_x[i];
      old_y[i] = m_y[i];
      m_bnc[i] = 0;
      m_vis[i] = en;
      if (!pa) begin
        if (m_cnt[i] == P_DIV[i] - 1) begin
          m_cnt[i] = 0;
          move_axis(m_x[i], m_dx[i], P_SX[i], LIM_X, fx);
          move_axis(m_y[i], m_dy[i], P_SY[i], LIM_Y, fy);
          m_bnc[i] = (fx || fy) ? 1 : 0;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  endtask

  // Any raster position except the last visible pixel, biased toward the two near-misses.
  task automatic drive_noise();
    int k;
    k = $urandom_range(0, 3);
    case (k)
      0: begin RASTER_X = 10'd639; RASTER_Y = 9'($urandom_range(0, 478)); end
      1: begin RASTER_X = 10'($urandom_range(0, 638)); RASTER_Y = 9'd479; end
      default: begin
        RASTER_X = 10'($urandom_range(0, 638));
        RASTER_Y = 9'($urandom_range(0, 479));
      end
    endcase
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RESET = 1'b0;
    drive_noise();
    #1;
    model_reset();
    for (int i = 0; i < N; i++) check_inst(i, "rst", m_x[i], m_y[i], 0, 0);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  // Visible-frame noise (outputs must hold, ENABLE/PAUSE wiggle), then one end-of-frame tick.
  task automatic run_frame(input int hold, input bit en, input bit pa, input int mid);
    repeat (mid) begin
      @(negedge CLK);
      for (int i = 0; i < N; i++) check_inst(i, "mid", m_x[i], m_y[i], m_vis[i], 0);
      drive_noise();
      ENABLE = 1'($urandom_range(0, 1));
      PAUSE  = 1'($urandom_range(0, 1));
    end
    @(negedge CLK);
    ENABLE   = en;
    PAUSE    = pa;
    RASTER_X = 10'd639;
    RASTER_Y = 9'd479;
    model_tick(en, pa);
    for (int c = 1; c <= 6; c++) begin
      @(posedge CLK);
      #1;
      if (c == hold) drive_noise();
      for (int i = 0; i < N; i++) begin
        if (c < 3)       check_inst(i, $sformatf("c%0d", c), old_x[i], old_y[i], m_vis[i], 0);
        else if (c == 3) check_inst(i, "c3", m_x[i], m_y[i], m_vis[i], m_bnc[i]);
        else             check_inst(i, $sformatf("c%0d", c), m_x[i], m_y[i], m_vis[i], 0);
      end
    end
  endtask

  // Take a tick right after reset (corner and near-wall instances bounce), then reset in COMMIT.
  task automatic abort_in_commit();
    @(negedge CLK);
    ENABLE   = 1'b1;
    PAUSE    = 1'b0;
    RASTER_X = 10'd639;
    RASTER_Y = 9'd479;
    @(posedge CLK);
    #1;
    drive_noise();
    check_inst(1, "pre_abort", P_IX[1], P_IY[1], 1, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < N; i++) check_inst(i, "abort", m_x[i], m_y[i], 0, 0);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    RESET    = 1'b0;
    ENABLE   = 1'b0;
    PAUSE    = 1'b0;
    RASTER_X = '0;
    RASTER_Y = '0;
    model_reset();
    apply_reset();

    // Ticks 1-6 unpaused (divided instance moves on 3 and 6), hold lengths 1..4.
    run_frame(1, 1'b1, 1'b0, 4);
    run_frame(2, 1'b1, 1'b0, 4);
    run_frame(4, 1'b0, 1'b0, 4);
    run_frame(3, 1'b1, 1'b0, 4);
    run_frame(1, 1'b0, 1'b0, 4);
    run_frame(2, 1'b1, 1'b0, 4);
    // Ticks 7-9 paused: positions hold, VISIBLE still follows ENABLE.
    run_frame(1, 1'b0, 1'b1, 4);
    run_frame(2, 1'b1, 1'b1, 4);
    run_frame(3, 1'b0, 1'b1, 4);

    // Reset while a bounce is waiting in COMMIT, then motion resumes from the INIT values.
    apply_reset();
    abort_in_commit();
    run_frame(1, 1'b1, 1'b0, 3);
    run_frame(2, 1'b1, 1'b0, 3);

    repeat (45) begin
      run_frame($urandom_range(1, 4), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), $urandom_range(1, 6));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
